// File: rtl/mem_ctrl_pkg.sv
// riscv_defs: shared encodings for the byte-serial memory controller
// (FSM states, MEM access-length codes, port owner codes).
package riscv_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_MM = 1'b1
    } owner_t;

    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd2;

    // Byte count of a MEM access; code 3 is treated as a word.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_B:   len_bytes = 3'd1;
            LEN_H:   len_bytes = 3'd2;
            LEN_W:   len_bytes = 3'd4;
            default: len_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates one byte-wide RAM port between instruction fetch and
// the MEM stage, serialising 1/2/4-byte accesses into byte cycles.
// Optional macro MEM_CTRL_FAIR_EN: after an MM grant, a pending IF wins the
// next contested grant (alternation); otherwise MM always beats IF.
// Handshake: a requester raises req with its operands and holds them until
// its done pulse; done is a single registered cycle during which read data is
// valid, and the requester drops or changes req at the edge ending it.
module mem_ctrl
    import riscv_defs::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              if_flush,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic              mm_req,
    input  logic              mm_we,
    input  logic [1:0]        mm_len,
    input  logic [31:0]       mm_addr,
    input  logic [31:0]       mm_wdata,
    output logic [31:0]       mm_rdata,
    output logic              mm_done,
    output logic              stl_if,
    output logic              stl_mm,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    state_t            r_state;
    owner_t            r_own;
    logic [2:0]        r_cnt;
    logic [2:0]        r_len;
    logic [31:0]       r_buf;
    logic [ADDR_W-1:0] r_ram_a;
    logic              r_ram_wr;
    logic [7:0]        r_ram_dout;
    logic [31:0]       r_if_data;
    logic [31:0]       r_mm_rdata;
    logic              r_if_done;
    logic              r_mm_done;
`ifdef MEM_CTRL_FAIR_EN
    logic              r_prefer_if;
`endif

    logic              w_grant_mm;
    logic              w_grant_if;
    logic [1:0]        w_rd_idx;
    logic [1:0]        w_wr_idx;
    logic [31:0]       w_buf_next;
    logic [7:0]        w_wr_byte;
    logic              w_unused;

    // Read byte arriving now belongs to the address issued one cycle earlier.
    assign w_rd_idx  = r_cnt[1:0] - 2'd1;
    assign w_wr_idx  = r_cnt[1:0] + 2'd1;
    assign w_wr_byte = mm_wdata[{w_wr_idx, 3'b000} +: 8];
    assign w_unused  = ^{if_addr[31:ADDR_W], mm_addr[31:ADDR_W]};

    // Grant decision, only meaningful while idle; flush blocks an IF grant.
    always_comb begin
        w_grant_mm = 1'b0;
        w_grant_if = 1'b0;
        if (r_state == IDLE) begin
`ifdef MEM_CTRL_FAIR_EN
            if (if_req && !if_flush && (!mm_req || r_prefer_if))
                w_grant_if = 1'b1;
            else if (mm_req)
                w_grant_mm = 1'b1;
`else
            if (mm_req)
                w_grant_mm = 1'b1;
            else if (if_req && !if_flush)
                w_grant_if = 1'b1;
`endif
        end
    end

    // Byte assembler: merge the incoming RAM byte into its lane.
    always_comb begin
        w_buf_next = r_buf;
        w_buf_next[{w_rd_idx, 3'b000} +: 8] = ram_din;
    end

    // Main FSM: grant, issue byte cycles, collect data, pulse done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_own      <= OWN_IF;
            r_cnt      <= 3'd0;
            r_len      <= 3'd0;
            r_buf      <= 32'd0;
            r_ram_a    <= '0;
            r_ram_wr   <= 1'b0;
            r_ram_dout <= 8'd0;
            r_if_data  <= 32'd0;
            r_mm_rdata <= 32'd0;
            r_if_done  <= 1'b0;
            r_mm_done  <= 1'b0;
`ifdef MEM_CTRL_FAIR_EN
            r_prefer_if <= 1'b0;
`endif
        end else begin
            r_if_done <= 1'b0;
            r_mm_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_mm) begin
                        r_own   <= OWN_MM;
                        r_len   <= len_bytes(mm_len);
                        r_cnt   <= 3'd0;
                        r_buf   <= 32'd0;
                        r_ram_a <= mm_addr[ADDR_W-1:0];
`ifdef MEM_CTRL_FAIR_EN
                        r_prefer_if <= 1'b1;
`endif
                        if (mm_we) begin
                            r_state    <= WR;
                            r_ram_wr   <= 1'b1;
                            r_ram_dout <= mm_wdata[7:0];
                        end else begin
                            r_state <= RD;
                        end
                    end else if (w_grant_if) begin
                        r_own   <= OWN_IF;
                        r_len   <= 3'd4;
                        r_cnt   <= 3'd0;
                        r_buf   <= 32'd0;
                        r_ram_a <= if_addr[ADDR_W-1:0];
                        r_state <= RD;
`ifdef MEM_CTRL_FAIR_EN
                        r_prefer_if <= 1'b0;
`endif
                    end
                end
                RD: begin
                    if (r_own == OWN_IF && if_flush) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt + 3'd1 < r_len)
                            r_ram_a <= r_ram_a + ADDR_W'(1);
                        if (r_cnt != 3'd0)
                            r_buf <= w_buf_next;
                        if (r_cnt == r_len) begin
                            r_state <= DONE;
                            if (r_own == OWN_IF) begin
                                r_if_data <= w_buf_next;
                                r_if_done <= 1'b1;
                            end else begin
                                r_mm_rdata <= w_buf_next;
                                r_mm_done  <= 1'b1;
                            end
                        end
                    end
                end
                WR: begin
                    if (r_cnt + 3'd1 < r_len) begin
                        r_cnt      <= r_cnt + 3'd1;
                        r_ram_a    <= r_ram_a + ADDR_W'(1);
                        r_ram_dout <= w_wr_byte;
                    end else begin
                        r_ram_wr  <= 1'b0;
                        r_state   <= DONE;
                        r_mm_done <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ram_a    = r_ram_a;
    assign ram_wr   = r_ram_wr;
    assign ram_dout = r_ram_dout;
    assign if_data  = r_if_data;
    assign if_done  = r_if_done;
    assign mm_rdata = r_mm_rdata;
    assign mm_done  = r_mm_done;
    assign stl_if   = if_req & ~r_if_done;
    assign stl_mm   = mm_req & ~r_mm_done;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: bench for mem_ctrl with a behavioural byte RAM, a
// transaction-level reference memory and an expected grant-order queue.
module tb_mem_ctrl;

`ifdef MEM_CTRL_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif
    localparam int ADDR_W = 17;
    localparam int MEM_SZ = 1 << ADDR_W;

    typedef struct {
        logic        we;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mm_txn_t;

    logic              clk;
    logic              rst;
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_flush;
    logic [31:0]       if_data;
    logic              if_done;
    logic              mm_req;
    logic              mm_we;
    logic [1:0]        mm_len;
    logic [31:0]       mm_addr;
    logic [31:0]       mm_wdata;
    logic [31:0]       mm_rdata;
    logic              mm_done;
    logic              stl_if;
    logic              stl_mm;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;

    logic [7:0]  ram     [0:MEM_SZ-1];
    logic [7:0]  ref_mem [0:MEM_SZ-1];
    logic [31:0] exp_q [$];
    logic [31:0] if_q [$];
    mm_txn_t     mm_q [$];
    bit          model_pref_if;
    int          n_tests;
    int          n_fail;

    mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_data(if_data), .if_done(if_done),
        .mm_req(mm_req), .mm_we(mm_we), .mm_len(mm_len), .mm_addr(mm_addr),
        .mm_wdata(mm_wdata), .mm_rdata(mm_rdata), .mm_done(mm_done),
        .stl_if(stl_if), .stl_mm(stl_mm),
        .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Byte RAM with one cycle read latency.
    always @(posedge clk) begin
        if (ram_wr) ram[ram_a] <= ram_dout;
        ram_din <= ram[ram_a];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic int len_n(input logic [1:0] len);
        return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    endfunction

    // Expected little-endian read of n bytes from the reference memory.
    function automatic logic [31:0] model_read(input logic [31:0] addr, input int n);
        logic [31:0] r;
        logic [16:0] a;
        r = 32'd0;
        for (int i = 0; i < n; i++) begin
            a = addr[16:0] + 17'(i);
            r = r | (32'(ref_mem[a]) << (8 * i));
        end
        return r;
    endfunction

    task automatic drive_mm(input mm_txn_t t);
        mm_we    = t.we;
        mm_len   = t.len;
        mm_addr  = t.addr;
        mm_wdata = t.wdata;
    endtask

    task automatic poke(input logic [16:0] a, input logic [7:0] d);
        ram[a]     = d;
        ref_mem[a] = d;
    endtask

    // Serves the queued IF/MM transactions with both requesters held
    // continuously while they have work; checks grant order, timing and data.
    task automatic run_queues(input int budget);
        int          a, b, pos, total, since, wr_k, n, exp_lat;
        bit          pref;
        logic [31:0] cur_if;
        logic [16:0] wa;
        mm_txn_t     cur_mm;
        exp_q.delete();
        a = if_q.size();
        b = mm_q.size();
        pref = model_pref_if;
        while (a > 0 || b > 0) begin
            if (a > 0 && (b == 0 || pref)) begin
                exp_q.push_back(32'd0); a--; pref = 1'b0;
            end else begin
                exp_q.push_back(32'd1); b--; pref = FAIR;
            end
        end
        total = exp_q.size();
        pos = 0; since = 0; wr_k = 0; cur_if = 32'd0;
        cur_mm = '{we: 1'b0, len: 2'd0, addr: 32'd0, wdata: 32'd0};
        if (if_q.size() > 0) begin
            cur_if = if_q.pop_front(); if_addr = cur_if; if_req = 1'b1;
        end
        if (mm_q.size() > 0) begin
            cur_mm = mm_q.pop_front(); drive_mm(cur_mm); mm_req = 1'b1;
        end
        for (int cyc = 0; cyc < budget && pos < total; cyc++) begin
            step();
            since++;
            if (ram_wr) begin
                if (mm_req && cur_mm.we && wr_k < 4) begin
                    wa = cur_mm.addr[16:0] + 17'(wr_k);
                    check_eq("wr_addr", 32'(ram_a), 32'(wa));
                    check_eq("wr_data", 32'(ram_dout), (cur_mm.wdata >> (8 * wr_k)) & 32'hFF);
                    wr_k++;
                end else begin
                    check_eq("wr_stray", 32'(ram_wr), 32'd0);
                end
            end
            if (if_req && !if_done) check_eq("stl_if", 32'(stl_if), 32'd1);
            if (mm_req && !mm_done) check_eq("stl_mm", 32'(stl_mm), 32'd1);
            if (if_done && pos < total) begin
                check_eq("order_if", 32'd0, exp_q[pos]);
                exp_lat = 6 + ((pos > 0) ? 1 : 0);
                check_eq("if_latency", since, exp_lat);
                check_eq("if_data", if_data, model_read(cur_if, 4));
                check_eq("stl_if_done", 32'(stl_if), 32'd0);
                pos++; since = 0; model_pref_if = 1'b0;
                if (if_q.size() > 0) begin
                    cur_if = if_q.pop_front(); if_addr = cur_if;
                end else begin
                    if_req = 1'b0;
                end
            end
            if (mm_done && pos < total) begin
                n = len_n(cur_mm.len);
                check_eq("order_mm", 32'd1, exp_q[pos]);
                exp_lat = n + (cur_mm.we ? 1 : 2) + ((pos > 0) ? 1 : 0);
                check_eq("mm_latency", since, exp_lat);
                if (cur_mm.we) begin
                    check_eq("wr_count", wr_k, n);
                    for (int i = 0; i < n; i++) begin
                        wa = cur_mm.addr[16:0] + 17'(i);
                        ref_mem[wa] = 8'((cur_mm.wdata >> (8 * i)) & 32'hFF);
                    end
                end else begin
                    check_eq("mm_rdata", mm_rdata, model_read(cur_mm.addr, n));
                end
                pos++; since = 0; wr_k = 0; model_pref_if = FAIR;
                if (mm_q.size() > 0) begin
                    cur_mm = mm_q.pop_front(); drive_mm(cur_mm);
                end else begin
                    mm_req = 1'b0;
                end
            end
        end
        check_eq("run_complete", pos, total);
        if_req = 1'b0;
        mm_req = 1'b0;
        if_q.delete();
        mm_q.delete();
        step();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom();
        if ($urandom_range(0, 3) == 0) a[16:0] = 17'h1FFFC + 17'($urandom_range(0, 3));
        return a;
    endfunction

    // stimulus and final report
    initial begin
        int flush_if_done, mm_seen_at, na, nb;
        mm_txn_t t;
        n_tests = 0; n_fail = 0; model_pref_if = 1'b0;
        for (int i = 0; i < MEM_SZ; i++) begin
            ram[i]     = 8'($urandom_range(0, 255));
            ref_mem[i] = ram[i];
        end
        rst = 1'b1; if_req = 1'b0; if_addr = 32'd0; if_flush = 1'b0;
        mm_req = 1'b0; mm_we = 1'b0; mm_len = 2'd0; mm_addr = 32'd0; mm_wdata = 32'd0;
        step(); step();
        check_eq("rst_ram_a", 32'(ram_a), 32'd0);
        check_eq("rst_ram_wr", 32'(ram_wr), 32'd0);
        check_eq("rst_ram_dout", 32'(ram_dout), 32'd0);
        check_eq("rst_if_data", if_data, 32'd0);
        check_eq("rst_mm_rdata", mm_rdata, 32'd0);
        check_eq("rst_if_done", 32'(if_done), 32'd0);
        check_eq("rst_mm_done", 32'(mm_done), 32'd0);
        rst = 1'b0;

        // IF word read of a known instruction
        poke(17'h100, 8'h13); poke(17'h101, 8'h00); poke(17'h102, 8'h50); poke(17'h103, 8'h00);
        if_q.push_back(32'h100);
        run_queues(20);
        check_eq("t2_if_word", if_data, 32'h0050_0013);

        // byte store at the top address
        mm_q.push_back('{we: 1'b1, len: 2'd0, addr: 32'h0001_FFFF, wdata: 32'h1234_56AB});
        run_queues(20);
        check_eq("t3_ram_top", 32'(ram[17'h1FFFF]), 32'h0000_00AB);

        // reset in the middle of a word read
        if_req = 1'b1; if_addr = 32'h40;
        step(); step(); step();
        rst = 1'b1; if_req = 1'b0;
        step();
        check_eq("t1_ram_wr", 32'(ram_wr), 32'd0);
        check_eq("t1_if_done", 32'(if_done), 32'd0);
        check_eq("t1_if_data", if_data, 32'd0);
        check_eq("t1_ram_a", 32'(ram_a), 32'd0);
        step();
        check_eq("t1_if_done2", 32'(if_done), 32'd0);
        rst = 1'b0; model_pref_if = 1'b0;

        // reset in the middle of a word store (data equal to memory contents)
        t = '{we: 1'b1, len: 2'd2, addr: 32'h500, wdata: model_read(32'h500, 4)};
        drive_mm(t); mm_req = 1'b1;
        step(); step();
        check_eq("t1b_wr_active", 32'(ram_wr), 32'd1);
        rst = 1'b1; mm_req = 1'b0;
        step();
        check_eq("t1b_ram_wr", 32'(ram_wr), 32'd0);
        check_eq("t1b_ram_dout", 32'(ram_dout), 32'd0);
        check_eq("t1b_mm_done", 32'(mm_done), 32'd0);
        step();
        rst = 1'b0; model_pref_if = 1'b0;
        if_q.push_back(32'h0);
        run_queues(20);

        // simultaneous IF and half-word MM load
        if_q.push_back(32'h200);
        mm_q.push_back('{we: 1'b0, len: 2'd1, addr: 32'h20, wdata: 32'd0});
        run_queues(40);
        check_eq("t4_mm_upper", mm_rdata & 32'hFFFF_0000, 32'd0);

        // flush in cycle 3 of an IF read, MM load waiting behind it
        if_req = 1'b1; if_addr = 32'h300;
        step(); step(); step();
        if_flush = 1'b1;
        t = '{we: 1'b0, len: 2'd2, addr: 32'h400, wdata: 32'd0};
        drive_mm(t); mm_req = 1'b1;
        flush_if_done = 0; mm_seen_at = 0;
        for (int k = 1; k <= 20 && mm_seen_at == 0; k++) begin
            step();
            if (if_done) flush_if_done++;
            if (k == 2) begin
                if_flush = 1'b0; if_req = 1'b0;
            end
            if (mm_done) begin
                mm_seen_at = k;
                check_eq("t5_mm_rdata", mm_rdata, model_read(32'h400, 4));
                mm_req = 1'b0;
            end
        end
        check_eq("t5_mm_latency", mm_seen_at, 7);
        check_eq("t5_no_if_done", flush_if_done, 0);
        if_flush = 1'b0; if_req = 1'b0; mm_req = 1'b0;
        model_pref_if = FAIR;
        step();

        // back-to-back MM with a pending IF
        mm_q.push_back('{we: 1'b0, len: 2'd2, addr: 32'h600, wdata: 32'd0});
        mm_q.push_back('{we: 1'b1, len: 2'd1, addr: 32'h610, wdata: 32'hCAFE_BEEF});
        if_q.push_back(32'h700);
        run_queues(60);

        // randomized mixes
        for (int r = 0; r < 12; r++) begin
            na = $urandom_range(0, 3);
            nb = $urandom_range(0, 3);
            if (na == 0 && nb == 0) nb = 1;
            for (int i = 0; i < na; i++) if_q.push_back(rand_addr());
            for (int i = 0; i < nb; i++) begin
                t.we    = 1'($urandom_range(0, 1));
                t.len   = 2'($urandom_range(0, 3));
                t.addr  = rand_addr();
                t.wdata = $urandom();
                mm_q.push_back(t);
            end
            run_queues(120);
        end

        // read back the store area written above through IF
        if_q.push_back(32'h610);
        run_queues(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
